spi_xfer_arbiter: RTL
=====================

# spi_xfer_arbiter

Multi-requester transaction controller that sits in front of the single-byte SPI master (`I_en`/`I_data_in`/`O_tx_done`/`O_rx_done`/`O_data_out`). It grants the SPI master to one of `NREQ` requesters (round-robin), sequences a burst of `len` bytes by holding `I_en` continuously, and feeds each transmit byte at the correct cycle. It returns each received byte to the granted requester and enforces a minimum CS-high gap between transactions.

## Interface
- `NREQ`, 2: number of requesters (2..4).
- `LEN_W`, 4: byte-count width; max burst is 2^LEN_W-1 bytes.
- `GAP`, 2: idle cycles (>=1) inserted after every transaction.

- `I_clk`  in  1  system clock (same clock as the SPI master).
- `I_rst`  in  1  reset, synchronous, active-high.
- `I_req`  in  NREQ  per-requester transaction request, level.
- `I_len`  in  NREQ*LEN_W  packed burst lengths; requester i at [i*LEN_W +: LEN_W].
- `I_tx_data`  in  NREQ*8  packed transmit bytes; requester i at [i*8 +: 8].
- `O_grant`  out  NREQ  one-hot owner of the SPI master; 0 when idle.
- `O_tx_ack`  out  NREQ  one-hot 1-cycle pulse: current `I_tx_data` byte consumed.
- `O_rx_data`  out  8  last received byte.
- `O_rx_valid`  out  NREQ  one-hot 1-cycle pulse qualifying `O_rx_data`.
- `O_done`  out  NREQ  one-hot 1-cycle pulse: transaction complete.
- `O_busy`  out  1  high in any state except IDLE.
- `O_spi_en`  out  1  drives master `I_en`.
- `O_spi_data`  out  8  drives master `I_data_in`.
- `I_spi_rx_done`  in  1  master `O_rx_done`.
- `I_spi_data`  in  8  master `O_data_out`.

## Operation
- All outputs are registered. Reset values: everything is 0, including `O_spi_en`, `O_spi_data`, `O_grant`, and `O_busy`.
- States: IDLE -> XFER -> DRAIN -> GAP -> IDLE.
- IDLE:
  - Eligible requester = `I_req[i]`=1 and `I_len[i]`!=0. Requests with len=0 are never granted.
  - Round-robin: search starts at (last granted + 1) mod NREQ. After reset the pointer is at NREQ-1, so requester 0 wins first.
  - On the grant edge:
    - set `O_grant`;
    - latch len into `rem`;
    - load `O_spi_data` from the winner's `I_tx_data`;
    - pulse `O_tx_ack`;
    - set `O_spi_en`=1 and `cnt`=0;
    - go to XFER.
- XFER: `cnt` (4-bit) increments every cycle, mirroring the master's internal state.
  - At the edge with `cnt`==15 and `rem`>1: decrement `rem`, load the next byte from `I_tx_data`, pulse `O_tx_ack`. `O_spi_en` stays high and the burst is continuous.
  - At the edge with `cnt`==15 and `rem`==1: clear `O_spi_en` and go to DRAIN.
- DRAIN: one cycle, to capture the final rx byte. At its edge, pulse `O_done`[owner], clear `O_grant`, and go to GAP.
- GAP: `GAP` cycles, then IDLE.
- RX capture, in XFER and DRAIN only:
  - Capture on the rising edge of `I_spi_rx_done` (`I_spi_rx_done` & ~registered copy). The master holds rx_done for 2 cycles mid-burst, and each byte must be reported exactly once.
  - On capture, `O_rx_data` <= `I_spi_data` and `O_rx_valid` <= `O_grant`.
- Mid-transaction changes to `I_req`, `I_len`, or other requesters are ignored; the burst always completes `len` bytes.
- A requester that still holds `I_req` after `O_done` is treated as a new request and arbitrates again.
- `I_rst` mid-burst: all outputs clear at that edge. `O_spi_en`=0 aborts the master. No `O_done` is issued.

## Timing
- Let the grant edge be at the end of cycle 0.
  - `O_spi_en` is high in cycles 1..16N.
  - `O_tx_ack` for byte k (k>=1) is visible in cycle 16k+1.
  - `O_spi_data` for byte k is stable in cycles 16k+1..16k+16.
- Requester data rule: `I_tx_data` of the owner is sampled on the edge that raises `O_tx_ack`. The requester must present the next byte no later than 15 cycles after seeing the ack.
- `O_rx_valid` for byte k (k=0..N-1) is visible in cycle 16k+18.
- `O_done` is visible in cycle 16N+2, coincident with the last `O_rx_valid`.
- `O_spi_en` low gap between back-to-back transactions is GAP+2 cycles.
- The earliest next grant is at the edge ending cycle 16N+GAP+2.

## Test plan
- Single byte: req0=1, len0=1, tx0=0xA5, slave loopback MISO=MOSI.
  - Required: `O_spi_en` high cycles 1..16; one `O_rx_valid`=01 with `O_rx_data`=0xA5; `O_done`=01 in the same cycle; `O_busy` falls after GAP.
- Burst: len0=3, requester advances 0x11/0x22/0x33 on each ack, loopback.
  - Required: en continuously high for 48 cycles.
  - Required: exactly 3 `O_tx_ack` and 3 `O_rx_valid` pulses, with data 0x11, 0x22, 0x33, spaced 16 cycles apart.
  - Required: no duplicate rx pulse.
- Round-robin: req0 and req1 held high continuously, len=2 each.
  - Required: grants alternate 0,1,0,1.
  - Required: en is low for exactly GAP+2 cycles between transactions.
- Len zero / late requester: req1=1 with len1=0 and req0=1 with len0=1 → only requester 0 is granted. Dropping req0 mid-burst still yields the full transfer and `O_done`.
- Reset mid-burst: assert `I_rst` at cycle 20 of a len=3 burst.
  - Required: the next cycle shows all outputs 0 and no `O_done`.
  - Required: a new request after reset is granted to requester 0 first.
- Slave pattern: MISO driven 0x3C independent of MOSI, tx=0xFF, len=2 → rx bytes are 0x3C, 0x3C.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin front end for a single-byte SPI master.
// Grants one requester at a time, holds the master enable across a burst of
// `len` bytes, feeds each transmit byte on the master's byte boundary and
// returns every received byte exactly once to the owner.
module spi_xfer_arbiter #(
  parameter int NREQ  = 2,
  parameter int LEN_W = 4,
  parameter int GAP   = 2
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic [NREQ-1:0]       I_req,
  input  logic [NREQ*LEN_W-1:0] I_len,
  input  logic [NREQ*8-1:0]     I_tx_data,
  output logic [NREQ-1:0]       O_grant,
  output logic [NREQ-1:0]       O_tx_ack,
  output logic [7:0]            O_rx_data,
  output logic [NREQ-1:0]       O_rx_valid,
  output logic [NREQ-1:0]       O_done,
  output logic                  O_busy,
  output logic                  O_spi_en,
  output logic [7:0]            O_spi_data,
  input  logic                  I_spi_rx_done,
  input  logic [7:0]            I_spi_data
);

  localparam int PW = (NREQ > 2) ? 2 : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DRAIN,
    ST_GAP
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [LEN_W-1:0]  rem, rem_nxt;
  logic [GW-1:0]     gcnt, gcnt_nxt;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic              rx_done_q;
  logic              rx_rise;

  logic [NREQ-1:0]   grant_nxt, tx_ack_nxt, rx_valid_nxt, done_nxt;
  logic [7:0]        rx_data_nxt, spi_data_nxt;
  logic              busy_nxt, spi_en_nxt;

  logic [NREQ-1:0]   eligible;
  logic              found;
  logic [PW-1:0]     win;
  logic [NREQ-1:0]   win_oh;
  logic [PW-1:0]     sel_idx;
  logic [LEN_W-1:0]  len_sel;
  logic [7:0]        tx_sel;

  assign rx_rise = I_spi_rx_done & ~rx_done_q;

  // A requester may compete only while requesting with a non-zero length.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = I_req[i] && (I_len[i*LEN_W +: LEN_W] != '0);
    end
  end

  // Round-robin search starting one past the last owner.
  always_comb begin : arb
    int unsigned idx;
    idx    = 0;
    win    = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && eligible[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  // Length/byte mux: the winner while idle, the current owner otherwise.
  always_comb begin
    sel_idx = (state == ST_IDLE) ? win : ptr;
    len_sel = '0;
    tx_sel  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel_idx == PW'(i)) begin
        len_sel = I_len[i*LEN_W +: LEN_W];
        tx_sel  = I_tx_data[i*8 +: 8];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rem_nxt      = rem;
    gcnt_nxt     = gcnt;
    ptr_nxt      = ptr;
    grant_nxt    = O_grant;
    tx_ack_nxt   = '0;
    rx_valid_nxt = '0;
    rx_data_nxt  = O_rx_data;
    done_nxt     = '0;
    spi_en_nxt   = O_spi_en;
    spi_data_nxt = O_spi_data;

    // The master holds rx_done for two cycles; only its rising edge counts.
    if ((state == ST_XFER || state == ST_DRAIN) && rx_rise) begin
      rx_data_nxt  = I_spi_data;
      rx_valid_nxt = O_grant;
    end

    unique case (state)
      ST_IDLE: begin
        if (found) begin
          grant_nxt    = win_oh;
          ptr_nxt      = win;
          rem_nxt      = len_sel;
          spi_data_nxt = tx_sel;
          tx_ack_nxt   = win_oh;
          spi_en_nxt   = 1'b1;
          cnt_nxt      = '0;
          state_nxt    = ST_XFER;
        end
      end
      ST_XFER: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == 4'd15) begin
          if (rem > LEN_W'(1)) begin
            rem_nxt      = rem - LEN_W'(1);
            spi_data_nxt = tx_sel;
            tx_ack_nxt   = O_grant;
          end else begin
            spi_en_nxt = 1'b0;
            state_nxt  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        done_nxt  = O_grant;
        grant_nxt = '0;
        gcnt_nxt  = '0;
        state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (gcnt == GW'(GAP - 1)) begin
          state_nxt = ST_IDLE;
        end else begin
          gcnt_nxt = gcnt + GW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and registered outputs; reset leaves the pointer so requester 0 wins first.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rem        <= '0;
      gcnt       <= '0;
      ptr        <= PW'(NREQ - 1);
      rx_done_q  <= 1'b0;
      O_grant    <= '0;
      O_tx_ack   <= '0;
      O_rx_data  <= '0;
      O_rx_valid <= '0;
      O_done     <= '0;
      O_busy     <= 1'b0;
      O_spi_en   <= 1'b0;
      O_spi_data <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rem        <= rem_nxt;
      gcnt       <= gcnt_nxt;
      ptr        <= ptr_nxt;
      rx_done_q  <= I_spi_rx_done;
      O_grant    <= grant_nxt;
      O_tx_ack   <= tx_ack_nxt;
      O_rx_data  <= rx_data_nxt;
      O_rx_valid <= rx_valid_nxt;
      O_done     <= done_nxt;
      O_busy     <= busy_nxt;
      O_spi_en   <= spi_en_nxt;
      O_spi_data <= spi_data_nxt;
    end
  end

endmodule
